// File: rtl/line_buffer_3row.sv
// Three-row line buffer: keeps the two previous image lines in column-indexed
// memories and emits {r-2, r-1, r} pixels for the same column, one cycle late.
module line_buffer_3row #(
    parameter int WIDTH      = 24,
    parameter int PIC_WIDTH  = 320,
    parameter int PIC_HEIGHT = 240
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic [WIDTH-1:0] dout3,
    output logic             valid_out,
    output logic             frame_done
);

    localparam int CW = (PIC_WIDTH  > 1) ? $clog2(PIC_WIDTH)  : 1;
    localparam int RW = (PIC_HEIGHT > 1) ? $clog2(PIC_HEIGHT) : 1;

    logic [CW-1:0]    col_cnt;
    logic [RW-1:0]    row_cnt;
    logic [WIDTH-1:0] m1 [PIC_WIDTH];
    logic [WIDTH-1:0] m2 [PIC_WIDTH];
    logic             accept;
    logic             last_col;
    logic             last_row;

    // A pixel arriving together with clear (or during reset) is dropped.
    assign accept   = rst_n && !clear && valid_in;
    assign last_col = (col_cnt == CW'(PIC_WIDTH - 1));
    assign last_row = (row_cnt == RW'(PIC_HEIGHT - 1));

    // Line memories are never reset; the row_cnt gate hides stale contents.
    // Nonblocking writes give read-before-write at the same column.
    always_ff @(posedge clk) begin
        if (accept) begin
            m1[col_cnt] <= din;
            m2[col_cnt] <= m1[col_cnt];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_cnt    <= '0;
            row_cnt    <= '0;
            dout1      <= '0;
            dout2      <= '0;
            dout3      <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else if (clear) begin
            col_cnt    <= '0;
            row_cnt    <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else if (valid_in) begin
            dout3      <= din;
            dout2      <= m1[col_cnt];
            dout1      <= m2[col_cnt];
            valid_out  <= (32'(row_cnt) >= 32'd2);
            frame_done <= last_col && last_row;
            if (last_col) begin
                col_cnt <= '0;
                row_cnt <= last_row ? '0 : row_cnt + 1'b1;
            end else begin
                col_cnt <= col_cnt + 1'b1;
            end
        end else begin
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_line_buffer_3row.sv
// Bench for line_buffer_3row on a 4x4 image: directed frames, gaps, clear,
// mid-frame reset and random traffic against an image-array reference model.
module tb_line_buffer_3row;

    localparam int W  = 24;
    localparam int PW = 4;
    localparam int PH = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clear;
    logic         valid_in;
    logic [W-1:0] din;
    logic [W-1:0] dout1, dout2, dout3;
    logic         valid_out, frame_done;

    int checks = 0;
    int errors = 0;

    // reference model: the current frame as a picture plus raster position
    logic [W-1:0] img [PH][PW];
    int           m_row, m_col;
    logic [W-1:0] e_d1, e_d2, e_d3;
    logic         k_d1, k_d2;
    logic         e_v, e_fd;
    int           v_cnt, fd_cnt;

    line_buffer_3row #(.WIDTH(W), .PIC_WIDTH(PW), .PIC_HEIGHT(PH)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .valid_in(valid_in), .din(din),
        .dout1(dout1), .dout2(dout2), .dout3(dout3),
        .valid_out(valid_out), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic r, input logic v, input logic c, input logic [W-1:0] d);
        if (!r) begin
            m_row = 0; m_col = 0;
            e_d1 = '0; e_d2 = '0; e_d3 = '0; k_d1 = 1'b1; k_d2 = 1'b1;
            e_v = 1'b0; e_fd = 1'b0;
        end else if (c || !v) begin
            if (c) begin m_row = 0; m_col = 0; end
            e_v = 1'b0; e_fd = 1'b0;
        end else begin
            img[m_row][m_col] = d;
            e_d3 = d;
            if (m_row >= 2) begin
                e_d1 = img[m_row-2][m_col]; e_d2 = img[m_row-1][m_col];
                k_d1 = 1'b1; k_d2 = 1'b1;
            end else if (m_row == 1) begin
                e_d2 = img[0][m_col]; k_d2 = 1'b1; k_d1 = 1'b0;
            end else begin
                k_d1 = 1'b0; k_d2 = 1'b0;
            end
            e_v  = (m_row >= 2);
            e_fd = (m_row == PH-1) && (m_col == PW-1);
            m_col++;
            if (m_col == PW) begin
                m_col = 0;
                m_row = (m_row == PH-1) ? 0 : m_row + 1;
            end
        end
    endtask

    task automatic step(input logic r, input logic v, input logic c, input logic [W-1:0] d);
        rst_n = r; valid_in = v; clear = c; din = d;
        @(posedge clk);
        model(r, v, c, d);
        #1;
        check("valid_out", W'(valid_out), W'(e_v));
        check("frame_done", W'(frame_done), W'(e_fd));
        check("dout3", dout3, e_d3);
        if (k_d2) check("dout2", dout2, e_d2);
        if (k_d1) check("dout1", dout1, e_d1);
        if (valid_out) v_cnt++;
        if (frame_done) fd_cnt++;
    endtask

    // one 4x4 frame of row*16+col+offset; gap inserts an idle cycle after each pixel
    task automatic send_frame(input logic [W-1:0] offset, input bit gap);
        for (int i = 0; i < PW*PH; i++) begin
            step(1'b1, 1'b1, 1'b0, offset + W'((i / PW) * 16 + (i % PW)));
            if (gap) step(1'b1, 1'b0, 1'b0, W'($urandom));
        end
    endtask

    initial begin
        // reset held with active input
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 24'hFFFFFF);
        check("rst_dout1", dout1, 24'h0);
        check("rst_dout2", dout2, 24'h0);
        check("rst_dout3", dout3, 24'h0);

        // continuous frame with the directed alignment point at pixel (2,1)
        v_cnt = 0; fd_cnt = 0;
        for (int i = 0; i < PW*PH; i++) begin
            step(1'b1, 1'b1, 1'b0, W'((i / PW) * 16 + (i % PW)));
            if (i == 9) begin
                check("align_d1", dout1, 24'h01);
                check("align_d2", dout2, 24'h11);
                check("align_d3", dout3, 24'h21);
                check("align_v", W'(valid_out), 24'h1);
            end
        end
        check("frame_a_valid_count", W'(v_cnt), W'(8));
        check("frame_a_done_count", W'(fd_cnt), W'(1));

        // back-to-back frame with offset
        v_cnt = 0; fd_cnt = 0;
        send_frame(24'h100, 1'b0);
        check("frame_b_valid_count", W'(v_cnt), W'(8));
        check("frame_b_done_count", W'(fd_cnt), W'(1));

        // same stream with idle cycles between pixels
        v_cnt = 0; fd_cnt = 0;
        send_frame(24'h0, 1'b1);
        check("gap_valid_count", W'(v_cnt), W'(8));
        check("gap_done_count", W'(fd_cnt), W'(1));

        // clear mid-row 2 with a pixel present, then a full frame
        for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b0, W'($urandom));
        step(1'b1, 1'b1, 1'b1, 24'hABCDEF);
        check("clear_v", W'(valid_out), 24'h0);
        v_cnt = 0; fd_cnt = 0;
        send_frame(24'h200, 1'b0);
        check("clear_valid_count", W'(v_cnt), W'(8));
        check("clear_done_count", W'(fd_cnt), W'(1));

        // reset mid-row 3, then a full frame
        for (int i = 0; i < 13; i++) step(1'b1, 1'b1, 1'b0, W'($urandom));
        step(1'b0, 1'b1, 1'b0, 24'h123456);
        check("mid_rst_d1", dout1, 24'h0);
        check("mid_rst_d3", dout3, 24'h0);
        v_cnt = 0; fd_cnt = 0;
        send_frame(24'h300, 1'b0);
        check("mid_rst_valid_count", W'(v_cnt), W'(8));

        // random traffic with occasional clear
        for (int i = 0; i < 600; i++)
            step(1'b1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 60) == 0), W'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
